// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and helpers for the 4-way round-robin bus arbiter
package mux_arb_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam logic [1:0] SEL_A = 2'b00;
   localparam logic [1:0] SEL_B = 2'b01;
   localparam logic [1:0] SEL_C = 2'b10;
   localparam logic [1:0] SEL_D = 2'b11;

   localparam int DEF_MAX_HOLD = 4;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux_arb4_if.sv
// rtl/mux_arb4_if.sv - request/grant bundle between requesting units and the bus arbiter
interface mux_arb4_if;
   logic [3:0] req;
   logic [3:0] lock;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       expire;

   modport master (output req, output lock, input gnt, input sel, input busy, input expire);
   modport slave  (input req, input lock, output gnt, output sel, output busy, output expire);
endinterface

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - rotating priority encoder: first set bit of req&mask scanning up from ptr
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [3:0] mask,
   input  logic [1:0] ptr,
   output logic       found,
   output logic [1:0] idx
);
   logic [3:0] w_cand;
   logic [1:0] w_j;

   assign w_cand = req & mask;

   // Walk from the farthest slot back to ptr so the nearest candidate is written last.
   always_comb begin
      found = 1'b0;
      idx   = ptr;
      w_j   = ptr;
      for (int i = 3; i >= 0; i--) begin
         w_j = ptr + 2'(i);
         if (w_cand[w_j]) begin
            found = 1'b1;
            idx   = w_j;
         end
      end
   end
endmodule

// File: rtl/mux_arb4.sv
// rtl/mux_arb4.sv - round-robin arbiter with hold limit and lock driving the shared 32-bit bus mux select
module mux_arb4
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int HOLD_W   = 8
) (
   input  logic           clk,
   input  logic           rst,
   mux_arb4_if.slave      bus
);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic [0:0]        r_state;
   logic [3:0]        r_gnt;
   logic [1:0]        r_sel;
   logic [1:0]        r_ptr;
   logic [HOLD_W-1:0] r_hold;
   logic              r_expire;

   logic [1:0]        w_scan_ptr;
   logic              w_any_found;
   logic [1:0]        w_any_idx;
   logic              w_oth_found;
   logic [1:0]        w_oth_idx;

   // While granted, every exit (release or rotation) scans from owner+1, the next ptr value.
   assign w_scan_ptr = (r_state == ST_GRANT) ? r_sel + 2'd1 : r_ptr;

   rr_pick4 u_pick_any (
      .req   (bus.req),
      .mask  (4'b1111),
      .ptr   (w_scan_ptr),
      .found (w_any_found),
      .idx   (w_any_idx)
   );

   rr_pick4 u_pick_oth (
      .req   (bus.req),
      .mask  (~r_gnt),
      .ptr   (w_scan_ptr),
      .found (w_oth_found),
      .idx   (w_oth_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_gnt    <= 4'b0000;
         r_sel    <= SEL_A;
         r_ptr    <= 2'd0;
         r_hold   <= '0;
         r_expire <= 1'b0;
      end else begin
         r_expire <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_found) begin
                  r_state <= ST_GRANT;
                  r_gnt   <= onehot4(w_any_idx);
                  r_sel   <= w_any_idx;
                  r_hold  <= '0;
               end else begin
                  r_gnt   <= 4'b0000;
               end
            end
            ST_GRANT: begin
               if (!bus.req[r_sel]) begin
                  r_ptr <= r_sel + 2'd1;
                  if (w_any_found) begin
                     r_gnt  <= onehot4(w_any_idx);
                     r_sel  <= w_any_idx;
                     r_hold <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_gnt   <= 4'b0000;
                  end
               end else if (bus.lock[r_sel]) begin
                  if (r_hold != HOLD_LAST) r_hold <= r_hold + 1'b1;
               end else if (r_hold == HOLD_LAST && w_oth_found) begin
                  r_ptr    <= r_sel + 2'd1;
                  r_gnt    <= onehot4(w_oth_idx);
                  r_sel    <= w_oth_idx;
                  r_hold   <= '0;
                  r_expire <= 1'b1;
               end else if (r_hold != HOLD_LAST) begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= 4'b0000;
            end
         endcase
      end
   end

   assign bus.gnt    = r_gnt;
   assign bus.sel    = r_sel;
   assign bus.busy   = |r_gnt;
   assign bus.expire = r_expire;
endmodule
